// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract sequencer for the CIM array periphery. It consumes
// per-lane AND/XOR bit-planes LSB-first and owns carry seeding, chaining and final capture.
module serial_addsub_seq #(
    parameter  int LANES    = 32,
    parameter  int MAX_BITS = 32,
    localparam int CW       = $clog2(MAX_BITS + 1)
) (
    input  logic             sys_clk_in,
    input  logic             sys_reset_in,
    input  logic             start_in,
    input  logic [CW-1:0]    op_bits_in,
    input  logic             sub_in,
    input  logic             chain_in,
    input  logic [LANES-1:0] lane_en_in,
    input  logic             bit_valid_in,
    input  logic [LANES-1:0] and_in,
    input  logic [LANES-1:0] xor_in,
    output logic             busy_out,
    output logic [LANES-1:0] sum_out,
    output logic             sum_valid_out,
    output logic [CW-1:0]    sum_idx_out,
    output logic             done_out,
    output logic [LANES-1:0] carry_out,
    output logic [LANES-1:0] ovf_out
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    n_q, n_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [LANES-1:0] mask_q, mask_d;
    logic [LANES-1:0] carry_q, carry_d;
    logic [LANES-1:0] sum_q, sum_d;
    logic             sum_valid_q, sum_valid_d;
    logic [CW-1:0]    sum_idx_q, sum_idx_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [LANES-1:0] carry_out_q, carry_out_d;
    logic [LANES-1:0] ovf_q, ovf_d;

    logic [LANES-1:0] sum_bit;
    logic [LANES-1:0] carry_nxt;
    logic             last_bit;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        bit_cnt_d   = bit_cnt_q;
        mask_d      = mask_q;
        carry_d     = carry_q;
        sum_d       = sum_q;
        sum_valid_d = 1'b0;
        sum_idx_d   = sum_idx_q;
        done_d      = 1'b0;
        carry_out_d = carry_out_q;
        ovf_d       = ovf_q;

        sum_bit   = (xor_in ^ carry_q) & mask_q;
        carry_nxt = ((xor_in & carry_q) | and_in) & mask_q;
        last_bit  = (bit_cnt_q == (n_q - CW'(1)));

        case (state_q)
            IDLE: begin
                if (start_in && (op_bits_in != '0)) begin
                    state_d     = RUN;
                    n_d         = (op_bits_in > CW'(MAX_BITS)) ? CW'(MAX_BITS) : op_bits_in;
                    mask_d      = lane_en_in;
                    bit_cnt_d   = '0;
                    carry_out_d = '0;
                    ovf_d       = '0;
                    // Chaining keeps the carry left by the previous op (0 after reset).
                    if (chain_in)
                        carry_d = carry_q & lane_en_in;
                    else if (sub_in)
                        carry_d = lane_en_in;
                    else
                        carry_d = '0;
                end
            end
            RUN: begin
                if (bit_valid_in) begin
                    sum_d       = sum_bit;
                    sum_valid_d = 1'b1;
                    sum_idx_d   = bit_cnt_q;
                    bit_cnt_d   = bit_cnt_q + CW'(1);
                    carry_d     = carry_nxt;
                    if (last_bit) begin
                        carry_out_d = carry_nxt;
                        ovf_d       = (carry_q ^ carry_nxt) & mask_q;
                        done_d      = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk_in or posedge sys_reset_in) begin
        if (sys_reset_in) begin
            state_q     <= IDLE;
            n_q         <= '0;
            bit_cnt_q   <= '0;
            mask_q      <= '0;
            carry_q     <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            sum_idx_q   <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            carry_out_q <= '0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            bit_cnt_q   <= bit_cnt_d;
            mask_q      <= mask_d;
            carry_q     <= carry_d;
            sum_q       <= sum_d;
            sum_valid_q <= sum_valid_d;
            sum_idx_q   <= sum_idx_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            carry_out_q <= carry_out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy_out      = busy_q;
    assign sum_out       = sum_q;
    assign sum_valid_out = sum_valid_q;
    assign sum_idx_out   = sum_idx_q;
    assign done_out      = done_q;
    assign carry_out     = carry_out_q;
    assign ovf_out       = ovf_q;

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Directed bench for serial_addsub_seq with 4 lanes and 8-bit maximum operand.
module tb_serial_addsub_seq;

    localparam int LANES    = 4;
    localparam int MAX_BITS = 8;
    localparam int CW       = $clog2(MAX_BITS + 1);

    logic             sys_clk_in;
    logic             sys_reset_in;
    logic             start_in;
    logic [CW-1:0]    op_bits_in;
    logic             sub_in;
    logic             chain_in;
    logic [LANES-1:0] lane_en_in;
    logic             bit_valid_in;
    logic [LANES-1:0] and_in;
    logic [LANES-1:0] xor_in;
    logic             busy_out;
    logic [LANES-1:0] sum_out;
    logic             sum_valid_out;
    logic [CW-1:0]    sum_idx_out;
    logic             done_out;
    logic [LANES-1:0] carry_out;
    logic [LANES-1:0] ovf_out;

    int total;
    int bad;

    logic [31:0] sums;
    int          nsum;
    int          done_cyc;
    logic        idx_ok;

    serial_addsub_seq #(.LANES(LANES), .MAX_BITS(MAX_BITS)) dut (
        .sys_clk_in    (sys_clk_in),
        .sys_reset_in  (sys_reset_in),
        .start_in      (start_in),
        .op_bits_in    (op_bits_in),
        .sub_in        (sub_in),
        .chain_in      (chain_in),
        .lane_en_in    (lane_en_in),
        .bit_valid_in  (bit_valid_in),
        .and_in        (and_in),
        .xor_in        (xor_in),
        .busy_out      (busy_out),
        .sum_out       (sum_out),
        .sum_valid_out (sum_valid_out),
        .sum_idx_out   (sum_idx_out),
        .done_out      (done_out),
        .carry_out     (carry_out),
        .ovf_out       (ovf_out)
    );

    initial sys_clk_in = 1'b0;
    always #5 sys_clk_in = ~sys_clk_in;

    task automatic tick();
        @(posedge sys_clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issues one command and collects the sum planes by index; plane i of lane j is bit 4*i+j.
    task automatic run_op(input logic [CW-1:0] nb, input logic sb, input logic ch,
                          input logic [3:0] msk, input logic [31:0] andp, input logic [31:0] xorp,
                          input logic [15:0] vpat, input logic poke,
                          output logic [31:0] s, output int ns, output int dc, output logic iok);
        int p;
        int cyc;
        s = '0; ns = 0; dc = -1; iok = 1'b1; p = 0;
        start_in = 1'b1; op_bits_in = nb; sub_in = sb; chain_in = ch; lane_en_in = msk;
        bit_valid_in = 1'b0;
        tick();
        cyc = 1;
        start_in = 1'b0;
        check("busy_t1", {31'b0, busy_out}, 32'd1);
        for (int k = 0; k < 40 && dc < 0; k++) begin
            start_in     = poke && (k == 1);
            op_bits_in   = poke ? CW'(2) : nb;
            sub_in       = poke ? 1'b1 : sb;
            bit_valid_in = (k < 16) ? vpat[k] : 1'b1;
            and_in       = (p < 8) ? andp[4*p +: 4] : 4'h0;
            xor_in       = (p < 8) ? xorp[4*p +: 4] : 4'h0;
            if (bit_valid_in) p++;
            tick();
            cyc++;
            if (sum_valid_out) begin
                if (int'(sum_idx_out) != ns) iok = 1'b0;
                if (ns < 8) s[4*ns +: 4] = sum_out;
                ns++;
            end
            if (done_out) dc = cyc;
        end
        start_in = 1'b0;
        bit_valid_in = 1'b0;
        tick();
        check("idle_after", {31'b0, busy_out}, 32'd0);
    endtask

    initial begin
        total = 0; bad = 0;
        sys_reset_in = 1'b1;
        start_in = 1'b0; op_bits_in = '0; sub_in = 1'b0; chain_in = 1'b0;
        lane_en_in = '0; bit_valid_in = 1'b0; and_in = '0; xor_in = '0;
        #12;
        check("rst_busy",  {31'b0, busy_out}, 32'd0);
        check("rst_sum",   {28'b0, sum_out}, 32'd0);
        check("rst_sv",    {31'b0, sum_valid_out}, 32'd0);
        check("rst_done",  {31'b0, done_out}, 32'd0);
        check("rst_carry", {28'b0, carry_out}, 32'd0);
        check("rst_ovf",   {28'b0, ovf_out}, 32'd0);
        #1 sys_reset_in = 1'b0;
        tick();

        // Add lane0: 0101 + 0011 = 1000, signed overflow.
        run_op(4, 1'b0, 1'b0, 4'hF, 32'h0000_0001, 32'h0000_0110, 16'hFFFF, 1'b0,
               sums, nsum, done_cyc, idx_ok);
        check("add_sum",   sums, 32'h0000_1000);
        check("add_nsum",  nsum, 4);
        check("add_done",  done_cyc, 5);
        check("add_idx",   {31'b0, idx_ok}, 32'd1);
        check("add_carry", {28'b0, carry_out}, 32'h0);
        check("add_ovf",   {28'b0, ovf_out}, 32'h1);

        // Sub lane1: 0110 - 0010 = 0100; idle lanes see seed 1 against zero planes.
        run_op(4, 1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0000_2022, 16'hFFFF, 1'b0,
               sums, nsum, done_cyc, idx_ok);
        check("sub_sum",   sums, 32'h0000_020D);
        check("sub_carry", {28'b0, carry_out}, 32'h2);
        check("sub_ovf",   {28'b0, ovf_out}, 32'h0);

        // Chain 0x0F + 0x01 as two nibbles.
        run_op(4, 1'b0, 1'b0, 4'hF, 32'h0000_0001, 32'h0000_1110, 16'hFFFF, 1'b0,
               sums, nsum, done_cyc, idx_ok);
        check("chain_lo_sum",   sums, 32'h0000_0000);
        check("chain_lo_carry", {28'b0, carry_out}, 32'h1);
        check("chain_lo_ovf",   {28'b0, ovf_out}, 32'h0);
        run_op(4, 1'b0, 1'b1, 4'hF, 32'h0, 32'h0, 16'hFFFF, 1'b0,
               sums, nsum, done_cyc, idx_ok);
        check("chain_hi_sum",   sums, 32'h0000_0001);
        check("chain_hi_carry", {28'b0, carry_out}, 32'h0);

        // Add case again with stall pattern 1,0,0,1,1,0,1.
        run_op(4, 1'b0, 1'b0, 4'hF, 32'h0000_0001, 32'h0000_0110, 16'h0059, 1'b0,
               sums, nsum, done_cyc, idx_ok);
        check("stall_sum",  sums, 32'h0000_1000);
        check("stall_nsum", nsum, 4);
        check("stall_idx",  {31'b0, idx_ok}, 32'd1);
        check("stall_done", done_cyc, 8);
        check("stall_ovf",  {28'b0, ovf_out}, 32'h1);

        // Mask 0101 with and=1 on every lane; start_in poked during RUN.
        run_op(4, 1'b0, 1'b0, 4'h5, 32'h0000_FFFF, 32'h0, 16'hFFFF, 1'b1,
               sums, nsum, done_cyc, idx_ok);
        check("mask_sum",   sums, 32'h0000_5550);
        check("mask_nsum",  nsum, 4);
        check("mask_done",  done_cyc, 5);
        check("mask_carry", {28'b0, carry_out}, 32'h5);
        check("mask_ovf",   {28'b0, ovf_out}, 32'h0);

        // Zero-length start stays in IDLE.
        start_in = 1'b1; op_bits_in = '0; sub_in = 1'b0; chain_in = 1'b0; lane_en_in = 4'hF;
        tick();
        check("zero_busy0", {31'b0, busy_out}, 32'd0);
        start_in = 1'b0;
        tick();
        check("zero_busy1", {31'b0, busy_out}, 32'd0);

        // Clamp: 12 requested, 8 used. 0x7F + 0x01 = 0x80.
        run_op(12, 1'b0, 1'b0, 4'hF, 32'h0000_0001, 32'h0111_1110, 16'hFFFF, 1'b0,
               sums, nsum, done_cyc, idx_ok);
        check("clamp_sum",   sums, 32'h1000_0000);
        check("clamp_nsum",  nsum, 8);
        check("clamp_done",  done_cyc, 9);
        check("clamp_idx",   {31'b0, idx_ok}, 32'd1);
        check("clamp_carry", {28'b0, carry_out}, 32'h0);
        check("clamp_ovf",   {28'b0, ovf_out}, 32'h1);

        // Reset after two consumed bits, leaving a live carry in lane0.
        start_in = 1'b1; op_bits_in = 4; sub_in = 1'b0; chain_in = 1'b0; lane_en_in = 4'hF;
        tick();
        start_in = 1'b0;
        bit_valid_in = 1'b1; and_in = 4'h1; xor_in = 4'h0;
        tick();
        and_in = 4'h0; xor_in = 4'h1;
        tick();
        bit_valid_in = 1'b0;
        check("pre_rst_busy", {31'b0, busy_out}, 32'd1);
        #2 sys_reset_in = 1'b1;
        #1;
        check("mid_rst_busy",  {31'b0, busy_out}, 32'd0);
        check("mid_rst_sv",    {31'b0, sum_valid_out}, 32'd0);
        check("mid_rst_idx",   {28'b0, sum_idx_out}, 32'd0);
        check("mid_rst_done",  {31'b0, done_out}, 32'd0);
        check("mid_rst_carry", {28'b0, carry_out}, 32'd0);
        #2 sys_reset_in = 1'b0;
        tick();
        check("post_rst_busy", {31'b0, busy_out}, 32'd0);
        check("post_rst_done", {31'b0, done_out}, 32'd0);
        run_op(4, 1'b0, 1'b1, 4'hF, 32'h0, 32'h0, 16'hFFFF, 1'b0,
               sums, nsum, done_cyc, idx_ok);
        check("rst_chain_sum",   sums, 32'h0000_0000);
        check("rst_chain_carry", {28'b0, carry_out}, 32'h0);
        check("rst_chain_done",  done_cyc, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
